// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter slice.
// Build option ARB_RR_EN selects round-robin arbitration (default: fixed priority).
package mem_port_arbiter_pkg;

    localparam int WORD_WIDTH    = 8;
    localparam int ADDR_WIDTH    = 5;
    localparam int NUM_MEM_PORTS = 2;
    localparam int PORT_FETCH    = 0;
    localparam int PORT_DATA     = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_t;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter: two request ports sharing one response path.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int WW = WORD_WIDTH
);
    logic [1:0]         req;
    logic [1:0]         we;
    logic [1:0][AW-1:0] addr;
    logic [1:0][WW-1:0] wdata;
    logic [1:0]         gnt;
    logic [1:0]         rvalid;
    logic [WW-1:0]      rdata;
    logic [1:0]         err;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_port_arbiter_pick2.sv
// Winner select for two requesters; ARB_RR_EN picks round-robin, otherwise port 1 has priority.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

`ifdef ARB_RR_EN
    // Round-robin: on contention favour the port that did not win last time.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end
`else
    logic unused_last_s;
    assign unused_last_s = last;

    // Fixed priority: data port beats fetch port.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = 2'b10;
            default: win = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port word memory; one access in flight, 1-cycle read latency.
// Build option ARB_RR_EN enables round-robin arbitration and the last-grant register.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW        = ADDR_WIDTH,
    parameter int WW        = WORD_WIDTH,
    parameter int MEM_DEPTH = 20
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus,
    output logic                mem_en,
    output logic                mem_we,
    output logic [AW-1:0]       mem_addr,
    output logic [WW-1:0]       mem_wdata,
    input  logic [WW-1:0]       mem_rdata
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH);

    arb_state_t    state_r, state_nxt_s;
    logic          owner_r, owner_nxt_s;
    logic          pend_err_r, pend_err_nxt_s;
    logic          last_s;
    logic [1:0]    win_s;
    logic          win_port_s;
    logic          in_range_s;
    logic          grant_s;
    logic [1:0]    gnt_s, rvalid_s, err_s;
    logic [WW-1:0] rdata_s;
    logic          mem_en_s, mem_we_s;
    logic [AW-1:0] mem_addr_s;
    logic [WW-1:0] mem_wdata_s;

    arb_pick2 u_pick (
        .req  (bus.req),
        .last (last_s),
        .win  (win_s)
    );

    assign win_port_s = win_s[1];
    assign in_range_s = ({1'b0, bus.addr[win_port_s]} < DEPTH_W);

`ifdef ARB_RR_EN
    logic last_r;
    assign last_s = last_r;

    // Remember the most recent grant, out-of-range grants included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_r <= 1'b0;
        end else if (grant_s) begin
            last_r <= win_port_s;
        end else begin
            last_r <= last_r;
        end
    end
`else
    assign last_s = 1'b0;
`endif

    // Next state, grant and memory strobes; everything forced low while reset is held.
    always_comb begin
        state_nxt_s    = state_r;
        owner_nxt_s    = owner_r;
        pend_err_nxt_s = pend_err_r;
        grant_s        = 1'b0;
        gnt_s          = 2'b00;
        rvalid_s       = 2'b00;
        err_s          = 2'b00;
        rdata_s        = '0;
        mem_en_s       = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_s     = '0;
        mem_wdata_s    = '0;
        case (state_r)
            ST_IDLE: begin
                if (win_s != 2'b00) begin
                    grant_s = 1'b1;
                    gnt_s   = win_s;
                    if (in_range_s) begin
                        mem_en_s    = 1'b1;
                        mem_we_s    = bus.we[win_port_s];
                        mem_addr_s  = bus.addr[win_port_s];
                        mem_wdata_s = bus.wdata[win_port_s];
                    end else if (bus.we[win_port_s]) begin
                        err_s = win_s;
                    end else begin
                        err_s = 2'b00;
                    end
                    // Reads hold the bus for the response cycle; writes complete at grant.
                    if (!bus.we[win_port_s]) begin
                        state_nxt_s    = ST_RESP;
                        owner_nxt_s    = win_port_s;
                        pend_err_nxt_s = !in_range_s;
                    end else begin
                        state_nxt_s    = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
                rvalid_s    = port_onehot(owner_r);
                if (pend_err_r) begin
                    err_s   = port_onehot(owner_r);
                    rdata_s = '0;
                end else begin
                    rdata_s = mem_rdata;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (!reset) begin
            grant_s     = 1'b0;
            gnt_s       = 2'b00;
            rvalid_s    = 2'b00;
            err_s       = 2'b00;
            rdata_s     = '0;
            mem_en_s    = 1'b0;
            mem_we_s    = 1'b0;
            mem_addr_s  = '0;
            mem_wdata_s = '0;
        end else begin
            grant_s     = grant_s;
        end
    end

    // FSM state, response owner and pending out-of-range flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            owner_r    <= 1'b0;
            pend_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            pend_err_r <= pend_err_nxt_s;
        end
    end

    assign bus.gnt    = gnt_s;
    assign bus.rvalid = rvalid_s;
    assign bus.err    = err_s;
    assign bus.rdata  = rdata_s;
    assign mem_en     = mem_en_s;
    assign mem_we     = mem_we_s;
    assign mem_addr   = mem_addr_s;
    assign mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory model and a read-response scoreboard.
// Contention expectations follow ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    typedef struct {
        logic       port;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       mem_en, mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic [7:0] mem_model [32];
    logic [7:0] ref_mem [32];
    exp_t       sb_q [$];
    int         tests_run    = 0;
    int         tests_failed = 0;

    mem_port_arbiter_if bus_if ();

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port memory with registered read data.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] we,
                         input logic [4:0] a0, input logic [4:0] a1,
                         input logic [7:0] wd0, input logic [7:0] wd1);
        bus_if.req      = req;
        bus_if.we       = we;
        bus_if.addr[0]  = a0;
        bus_if.addr[1]  = a1;
        bus_if.wdata[0] = wd0;
        bus_if.wdata[1] = wd1;
    endtask

    // Grant-side checks, scoreboard push on read grants, pop on responses.
    always @(negedge clk) begin
        logic p;
        exp_t e;
        if (reset) begin
            if (bus_if.gnt != 2'b00) begin
                p = bus_if.gnt[1];
                chk("gnt_onehot", 32'(bus_if.gnt == 2'b01 || bus_if.gnt == 2'b10), 32'd1);
                chk("gnt_rvalid_excl", 32'(bus_if.rvalid), 32'd0);
                if (bus_if.addr[p] < 5'd20) begin
                    chk("mon_mem_en", 32'(mem_en), 32'd1);
                    chk("mon_mem_addr", 32'(mem_addr), 32'(bus_if.addr[p]));
                    chk("mon_mem_we", 32'(mem_we), 32'(bus_if.we[p]));
                    chk("mon_err_inrange", 32'(bus_if.err), 32'd0);
                    if (bus_if.we[p]) begin
                        chk("mon_mem_wdata", 32'(mem_wdata), 32'(bus_if.wdata[p]));
                        ref_mem[bus_if.addr[p]] = bus_if.wdata[p];
                    end else begin
                        sb_q.push_back('{port: p, data: ref_mem[bus_if.addr[p]], err: 1'b0});
                    end
                end else begin
                    chk("mon_mem_en_oor", 32'(mem_en), 32'd0);
                    if (bus_if.we[p]) begin
                        chk("mon_err_oor_wr", 32'(bus_if.err), 32'(bus_if.gnt));
                    end else begin
                        chk("mon_err_oor_rd_gnt", 32'(bus_if.err), 32'd0);
                        sb_q.push_back('{port: p, data: 8'h00, err: 1'b1});
                    end
                end
            end else if (bus_if.rvalid != 2'b00) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_rvalid", 32'(bus_if.rvalid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_rvalid", 32'(bus_if.rvalid), 32'(port_onehot(e.port)));
                    chk("sb_rdata", 32'(bus_if.rdata), 32'(e.data));
                    chk("sb_err", 32'(bus_if.err), e.err ? 32'(port_onehot(e.port)) : 32'd0);
                end
            end else begin
                chk("mon_idle_err", 32'(bus_if.err), 32'd0);
                chk("mon_idle_mem_en", 32'(mem_en), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] sus_exp [4];
`ifdef ARB_RR_EN
        sus_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        sus_exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        for (int i = 0; i < 32; i++) begin
            mem_model[i] <= 8'(i);
            ref_mem[i]    = 8'(i);
        end
        reset = 1'b0;
        drive(2'b01, 2'b00, 5'd3, 5'd0, 8'h00, 8'h00);
        #2;
        chk("rst_gnt", 32'(bus_if.gnt), 32'd0);
        chk("rst_rvalid", 32'(bus_if.rvalid), 32'd0);
        chk("rst_err", 32'(bus_if.err), 32'd0);
        chk("rst_rdata", 32'(bus_if.rdata), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Contention: both read; port 1 first, then port 0.
        drive(2'b11, 2'b00, 5'd1, 5'd2, 8'h00, 8'h00);
        #1 chk("cont_gnt1", 32'(bus_if.gnt), 32'd2);
        step();
        drive(2'b01, 2'b00, 5'd1, 5'd2, 8'h00, 8'h00);
        #1 chk("cont_resp1_gnt", 32'(bus_if.gnt), 32'd0);
        chk("cont_rvalid1", 32'(bus_if.rvalid), 32'd2);
        step();
        #1 chk("cont_gnt0", 32'(bus_if.gnt), 32'd1);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("cont_rvalid0", 32'(bus_if.rvalid), 32'd1);
        step();

        // Sustained contention.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 2'b00, 5'd4, 5'd5, 8'h00, 8'h00);
            #1 chk("sus_gnt", 32'(bus_if.gnt), 32'(sus_exp[i]));
            step();
            #1 chk("sus_rvalid", 32'(bus_if.rvalid), 32'(sus_exp[i]));
            chk("sus_resp_gnt", 32'(bus_if.gnt), 32'd0);
            step();
        end
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        step();

        // Single read and last legal address.
        drive(2'b01, 2'b00, 5'd7, 5'd0, 8'h00, 8'h00);
        #1 chk("rd_gnt", 32'(bus_if.gnt), 32'd1);
        chk("rd_mem_addr", 32'(mem_addr), 32'd7);
        chk("rd_mem_en", 32'(mem_en), 32'd1);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("rd_rvalid", 32'(bus_if.rvalid), 32'd1);
        chk("rd_rdata", 32'(bus_if.rdata), 32'd7);
        chk("rd_err", 32'(bus_if.err), 32'd0);
        step();
        drive(2'b01, 2'b00, 5'd19, 5'd0, 8'h00, 8'h00);
        #1 chk("rd19_mem_en", 32'(mem_en), 32'd1);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("rd19_rdata", 32'(bus_if.rdata), 32'd19);
        chk("rd19_err", 32'(bus_if.err), 32'd0);
        step();

        // Write then read-back on port 1.
        drive(2'b10, 2'b10, 5'd0, 5'd3, 8'h00, 8'hA5);
        #1 chk("wr_gnt", 32'(bus_if.gnt), 32'd2);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        step();
        drive(2'b10, 2'b00, 5'd0, 5'd3, 8'h00, 8'h00);
        #1 chk("wr_then_rd_gnt", 32'(bus_if.gnt), 32'd2);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("rb_rdata", 32'(bus_if.rdata), 32'hA5);
        step();

        // Out-of-range read and write.
        drive(2'b01, 2'b00, 5'd20, 5'd0, 8'h00, 8'h00);
        #1 chk("oor_rd_gnt", 32'(bus_if.gnt), 32'd1);
        chk("oor_rd_mem_en", 32'(mem_en), 32'd0);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("oor_rd_rvalid", 32'(bus_if.rvalid), 32'd1);
        chk("oor_rd_err", 32'(bus_if.err), 32'd1);
        chk("oor_rd_rdata", 32'(bus_if.rdata), 32'd0);
        step();
        drive(2'b10, 2'b10, 5'd0, 5'd31, 8'h00, 8'hFF);
        #1 chk("oor_wr_gnt", 32'(bus_if.gnt), 32'd2);
        chk("oor_wr_err", 32'(bus_if.err), 32'd2);
        chk("oor_wr_mem_en", 32'(mem_en), 32'd0);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("oor_wr_mem_kept", 32'(mem_model[31]), 32'd31);
        step();

        // Request arriving during RESP waits one cycle.
        drive(2'b01, 2'b00, 5'd6, 5'd0, 8'h00, 8'h00);
        #1 chk("dr_gnt0", 32'(bus_if.gnt), 32'd1);
        step();
        drive(2'b10, 2'b00, 5'd0, 5'd8, 8'h00, 8'h00);
        #1 chk("dr_resp_gnt", 32'(bus_if.gnt), 32'd0);
        chk("dr_rvalid0", 32'(bus_if.rvalid), 32'd1);
        step();
        #1 chk("dr_gnt1", 32'(bus_if.gnt), 32'd2);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("dr_rdata1", 32'(bus_if.rdata), 32'd8);
        step();

        // Reset during RESP drops the pending read.
        drive(2'b01, 2'b00, 5'd9, 5'd0, 8'h00, 8'h00);
        #1 chk("mr_gnt", 32'(bus_if.gnt), 32'd1);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("mr_in_resp", 32'(bus_if.rvalid), 32'd1);
        reset = 1'b0;
        #1 chk("mr_rvalid_cleared", 32'(bus_if.rvalid), 32'd0);
        chk("mr_err_cleared", 32'(bus_if.err), 32'd0);
        sb_q.delete();
        @(negedge clk);
        #1 reset = 1'b1;
        step();
        #1 chk("mr_no_rvalid", 32'(bus_if.rvalid), 32'd0);
        drive(2'b01, 2'b00, 5'd10, 5'd0, 8'h00, 8'h00);
        #1 chk("mr_regnt", 32'(bus_if.gnt), 32'd1);
        step();
        drive(2'b00, 2'b00, 5'd0, 5'd0, 8'h00, 8'h00);
        #1 chk("mr_rdata", 32'(bus_if.rdata), 32'd10);
        step();
        step();

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
